// File: rtl/tpu_host_pkg.sv
// Shared definitions for the TPU host buffer: address regions, status window,
// run-controller states and status bit layout.
package tpu_host_pkg;

    typedef enum logic [1:0] {
        REG_W = 2'b00,
        REG_A = 2'b01,
        REG_R = 2'b10,
        REG_S = 2'b11
    } region_e;

    localparam logic [7:0] ADDR_STATUS = 8'hC0;
    localparam logic [7:0] ADDR_CYC_LO = 8'hC1;
    localparam logic [7:0] ADDR_CYC_HI = 8'hC2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    localparam logic [15:0] CYCLES_MAX = 16'hFFFF;

endpackage

// File: rtl/tpu_byte_regfile.sv
// DEPTH x 8 byte buffer: synchronous write, asynchronous host read,
// registered core read and a synchronous clear-all.
module tpu_byte_regfile #(
    parameter int  DEPTH = 16,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [IW-1:0] raddr,
    output logic [7:0]    rdata,
    input  logic [IW-1:0] raddr_r,
    output logic [7:0]    rdata_r
);

    logic [7:0] mem [DEPTH];

    // NOTE: the array itself is reset because every buffer must read 0x00 after
    // any reset, mid-run included; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdata_r <= '0;
        end else begin
            if (clr) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (we) begin
                mem[waddr] <= wdata;
            end
            rdata_r <= mem[raddr_r];
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tpu_host_buffer.sv
// Host-side buffers and run controller between the UART bridge and the
// systolic core: address decode, one run per start pulse, busy/done/err.
module tpu_host_buffer
    import tpu_host_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter int  TIMEOUT = 65535,
    localparam int IW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    host_addr,
    input  logic [7:0]    host_wdata,
    input  logic          host_valid,
    input  logic          host_we,
    input  logic          host_start,
    output logic [7:0]    host_rdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          core_start,
    input  logic [IW-1:0] core_rd_idx,
    output logic [7:0]    core_weight,
    output logic [7:0]    core_act,
    input  logic          core_res_we,
    input  logic [IW-1:0] core_res_idx,
    input  logic [7:0]    core_res_data,
    input  logic          core_done
);

    localparam logic [16:0] TIMEOUT_CYC = 17'(TIMEOUT);

    state_e      state, state_next;
    region_e     region;
    logic        host_wr, in_range, running;
    logic        w_we, a_we, res_we, host_viol;
    logic        start_ok, timeout_hit;
    logic [15:0] run_cycles, cycles_next;
    logic [7:0]  w_rd, a_rd, r_rd, status;
    logic [7:0]  unused_res_rd;

    assign host_wr  = host_valid & host_we;
    assign region   = region_e'(host_addr[7:6]);
    assign in_range = int'(host_addr[5:0]) < DEPTH;
    assign running  = (state == S_RUN);
    assign busy     = running;
    assign done     = (state == S_DONE);

    // Weight/activation writes are locked out while the core is consuming them.
    assign w_we      = host_wr && region == REG_W && in_range && !running;
    assign a_we      = host_wr && region == REG_A && in_range && !running;
    assign res_we    = running && core_res_we && (int'(core_res_idx) < DEPTH);
    assign host_viol = running &&
                       ((host_wr && (region == REG_W || region == REG_A)) || host_start);

    assign cycles_next = (run_cycles == CYCLES_MAX) ? run_cycles : run_cycles + 16'd1;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        start_ok    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (host_start) begin
                    start_ok   = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (core_done) begin
                    state_next = S_DONE;
                end else if ({1'b0, cycles_next} >= TIMEOUT_CYC) begin
                    timeout_hit = 1'b1;
                    state_next  = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_start <= 1'b0;
            err        <= 1'b0;
            run_cycles <= '0;
        end else begin
            core_start <= start_ok;
            if (start_ok)     run_cycles <= '0;
            else if (running) run_cycles <= cycles_next;
            if (start_ok)                      err <= 1'b0;
            else if (host_viol || timeout_hit) err <= 1'b1;
        end
    end

    always_comb begin
        status            = '0;
        status[STAT_BUSY] = busy;
        status[STAT_DONE] = done;
        status[STAT_ERR]  = err;
    end

    always_comb begin
        host_rdata = '0;
        case (region)
            REG_W: if (in_range) host_rdata = w_rd;
            REG_A: if (in_range) host_rdata = a_rd;
            REG_R: if (in_range) host_rdata = r_rd;
            REG_S: begin
                case (host_addr)
                    ADDR_STATUS: host_rdata = status;
                    ADDR_CYC_LO: host_rdata = run_cycles[7:0];
                    ADDR_CYC_HI: host_rdata = run_cycles[15:8];
                    default:     host_rdata = '0;
                endcase
            end
            default: host_rdata = '0;
        endcase
    end

    tpu_byte_regfile #(.DEPTH(DEPTH)) u_weights (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (1'b0),
        .we      (w_we),
        .waddr   (host_addr[IW-1:0]),
        .wdata   (host_wdata),
        .raddr   (host_addr[IW-1:0]),
        .rdata   (w_rd),
        .raddr_r (core_rd_idx),
        .rdata_r (core_weight)
    );

    tpu_byte_regfile #(.DEPTH(DEPTH)) u_acts (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (1'b0),
        .we      (a_we),
        .waddr   (host_addr[IW-1:0]),
        .wdata   (host_wdata),
        .raddr   (host_addr[IW-1:0]),
        .rdata   (a_rd),
        .raddr_r (core_rd_idx),
        .rdata_r (core_act)
    );

    // Results are only read by the host, so the registered port is left idle.
    tpu_byte_regfile #(.DEPTH(DEPTH)) u_results (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_ok),
        .we      (res_we),
        .waddr   (core_res_idx),
        .wdata   (core_res_data),
        .raddr   (host_addr[IW-1:0]),
        .rdata   (r_rd),
        .raddr_r ('0),
        .rdata_r (unused_res_rd)
    );

endmodule
